// File: rtl/fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_wr_ctrl -- write-side controller of an asynchronous FIFO.
//
// Keeps the binary and Gray write pointers, generates the memory write strobe
// and address, and derives full / almost_full / occupancy from a read pointer
// that has already been synchronised into the write clock domain. Because that
// read pointer is stale, occupancy is only ever over-reported, never under.
//
// Parameters
//   ADDR_W     address width, DEPTH = 2**ADDR_W (2..12)
//   AF_MARGIN  almost_full asserts when free entries <= AF_MARGIN (1..DEPTH-1)
//
// Ports
//   wr_clk            in   write-domain clock
//   wr_rst            in   asynchronous active-low reset
//   wr_en             in   write request from producer
//   rd_ptr_gray_sync  in   Gray read pointer, synchronised into wr_clk
//   ovf_clr           in   clears the sticky overflow flag
//   wr_mem_en         out  memory write strobe (combinational)
//   wr_addr           out  memory write address (next write location)
//   wr_ptr_gray       out  registered Gray write pointer
//   full              out  registered full flag
//   almost_full       out  registered almost-full flag
//   wr_level          out  registered write-side occupancy, 0..DEPTH
//   overflow          out  sticky: write attempted while full
// -----------------------------------------------------------------------------
module fifo_wr_ctrl #(
    parameter int ADDR_W    = 4,
    parameter int AF_MARGIN = 2
) (
    input  logic              wr_clk,
    input  logic              wr_rst,
    input  logic              wr_en,
    input  logic [ADDR_W:0]   rd_ptr_gray_sync,
    input  logic              ovf_clr,
    output logic              wr_mem_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W:0]   wr_ptr_gray,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   wr_level,
    output logic              overflow
);

    localparam int PW    = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [PW-1:0] AF_THRESH = PW'(DEPTH - AF_MARGIN);

    // Binary to Gray: exactly one bit changes per increment, including the wrap.
    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: prefix XOR starting from the MSB.
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b = g;
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] wr_bin_q,  wr_bin_d;
    logic [PW-1:0] wr_gray_q, wr_gray_d;
    logic          full_q,    full_d;
    logic          afull_q,   afull_d;
    logic [PW-1:0] level_q,   level_d;
    logic          ovf_q,     ovf_d;

    logic          wr_fire_s;
    logic [PW-1:0] rd_bin_s;
    logic [PW-1:0] full_cmp_s;

    // Next-state computation for pointers, flags and occupancy.
    always_comb begin
        wr_fire_s  = wr_en & ~full_q;
        wr_bin_d   = wr_bin_q + {{ADDR_W{1'b0}}, wr_fire_s};
        wr_gray_d  = bin2gray(wr_bin_d);
        rd_bin_s   = gray2bin(rd_ptr_gray_sync);
        // Full when the write pointer has lapped the read pointer once: in Gray
        // that means the two MSBs differ and all lower bits match.
        full_cmp_s = {~rd_ptr_gray_sync[ADDR_W:ADDR_W-1], rd_ptr_gray_sync[ADDR_W-2:0]};
        full_d     = (wr_gray_d == full_cmp_s);
        level_d    = wr_bin_d - rd_bin_s;
        afull_d    = (level_d >= AF_THRESH);
        // Setting overflow beats clearing it in the same cycle.
        if (wr_en && full_q) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge wr_clk or negedge wr_rst) begin
        if (!wr_rst) begin
            wr_bin_q  <= {PW{1'b0}};
            wr_gray_q <= {PW{1'b0}};
            full_q    <= 1'b0;
            afull_q   <= 1'b0;
            level_q   <= {PW{1'b0}};
            ovf_q     <= 1'b0;
        end else begin
            wr_bin_q  <= wr_bin_d;
            wr_gray_q <= wr_gray_d;
            full_q    <= full_d;
            afull_q   <= afull_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
        end
    end

    assign wr_mem_en   = wr_fire_s;
    assign wr_addr     = wr_bin_q[ADDR_W-1:0];
    assign wr_ptr_gray = wr_gray_q;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign wr_level    = level_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_ctrl -- directed self-checking bench for fifo_wr_ctrl
// (ADDR_W=4, AF_MARGIN=2): fill, overflow set/clear, drain release,
// asynchronous reset mid-fill and pointer wrap with a trailing read pointer.
// -----------------------------------------------------------------------------
module tb_fifo_wr_ctrl;

    logic       wr_clk;
    logic       wr_rst;
    logic       wr_en;
    logic [4:0] rd_ptr_gray_sync;
    logic       ovf_clr;
    logic       wr_mem_en;
    logic [3:0] wr_addr;
    logic [4:0] wr_ptr_gray;
    logic       full;
    logic       almost_full;
    logic [4:0] wr_level;
    logic       overflow;

    int n_cmp;
    int n_bad;

    fifo_wr_ctrl #(
        .ADDR_W    (4),
        .AF_MARGIN (2)
    ) dut (
        .wr_clk           (wr_clk),
        .wr_rst           (wr_rst),
        .wr_en            (wr_en),
        .rd_ptr_gray_sync (rd_ptr_gray_sync),
        .ovf_clr          (ovf_clr),
        .wr_mem_en        (wr_mem_en),
        .wr_addr          (wr_addr),
        .wr_ptr_gray      (wr_ptr_gray),
        .full             (full),
        .almost_full      (almost_full),
        .wr_level         (wr_level),
        .overflow         (overflow)
    );

    // 10 ns write clock.
    initial begin
        wr_clk = 1'b0;
        forever #5 wr_clk = ~wr_clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] g5(input int n);
        logic [4:0] b;
        b = n[4:0];
        return b ^ (b >> 1);
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    // Pulse reset between clock edges and check outputs clear before any edge.
    task automatic async_reset(input string tag);
        #2;
        wr_rst = 1'b0;
        #1;
        check_val({tag, "_gray"},  32'(wr_ptr_gray), 32'd0);
        check_val({tag, "_full"},  32'(full),        32'd0);
        check_val({tag, "_af"},    32'(almost_full), 32'd0);
        check_val({tag, "_level"}, 32'(wr_level),    32'd0);
        check_val({tag, "_ovf"},   32'(overflow),    32'd0);
        check_val({tag, "_addr"},  32'(wr_addr),     32'd0);
        #1;
        wr_rst = 1'b1;
    endtask

    initial begin
        int strobes;
        int lvl;
        logic [4:0] prev_gray;

        n_cmp            = 0;
        n_bad            = 0;
        wr_rst           = 1'b0;
        wr_en            = 1'b0;
        rd_ptr_gray_sync = 5'd0;
        ovf_clr          = 1'b0;

        // Reset state.
        #3;
        check_val("rst_gray",  32'(wr_ptr_gray), 32'd0);
        check_val("rst_full",  32'(full),        32'd0);
        check_val("rst_level", 32'(wr_level),    32'd0);
        check_val("rst_ovf",   32'(overflow),    32'd0);
        check_val("rst_mem_en", 32'(wr_mem_en),  32'd0);
        @(negedge wr_clk);
        wr_rst = 1'b1;

        // Fill from empty: 17 requests, 16 accepted, 17th sets overflow.
        strobes = 0;
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1;
            #1;
            check_val("fill_mem_en", 32'(wr_mem_en), (i < 16) ? 32'd1 : 32'd0);
            check_val("fill_addr",   32'(wr_addr),   32'(i % 16));
            if (wr_mem_en) strobes++;
            tick();
            lvl = (i < 16) ? i + 1 : 16;
            check_val("fill_level", 32'(wr_level),    32'(lvl));
            check_val("fill_full",  32'(full),        (lvl == 16) ? 32'd1 : 32'd0);
            check_val("fill_af",    32'(almost_full), (lvl >= 14) ? 32'd1 : 32'd0);
            check_val("fill_gray",  32'(wr_ptr_gray), 32'(g5(lvl)));
            check_val("fill_ovf",   32'(overflow),    (i == 16) ? 32'd1 : 32'd0);
        end
        check_val("fill_strobes", 32'(strobes), 32'd16);
        check_val("fill_gray16",  32'(wr_ptr_gray), 32'b11000);

        // Overflow: set wins over clear while full, then clear with no request.
        wr_en   = 1'b1;
        ovf_clr = 1'b1;
        tick();
        check_val("ovf_set_wins", 32'(overflow), 32'd1);
        wr_en = 1'b0;
        tick();
        check_val("ovf_cleared", 32'(overflow), 32'd0);
        ovf_clr = 1'b0;
        check_val("ovf_full_hold", 32'(full), 32'd1);
        check_val("ovf_gray_hold", 32'(wr_ptr_gray), 32'b11000);

        // Drain release: read pointer advances to 1.
        rd_ptr_gray_sync = 5'b00001;
        tick();
        check_val("drain_full",  32'(full),        32'd0);
        check_val("drain_level", 32'(wr_level),    32'd15);
        check_val("drain_af",    32'(almost_full), 32'd1);
        wr_en = 1'b1;
        #1;
        check_val("drain_mem_en", 32'(wr_mem_en), 32'd1);
        check_val("drain_addr",   32'(wr_addr),   32'd0);
        tick();
        wr_en = 1'b0;
        check_val("refill_full",  32'(full),     32'd1);
        check_val("refill_level", 32'(wr_level), 32'd16);
        check_val("refill_gray",  32'(wr_ptr_gray), 32'b11001);

        // Asynchronous reset in the middle of a fill at level 9.
        async_reset("clr1");
        rd_ptr_gray_sync = 5'd0;
        wr_en = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        wr_en = 1'b0;
        check_val("mid_level", 32'(wr_level), 32'd9);
        check_val("mid_addr",  32'(wr_addr),  32'd9);
        async_reset("midrst");
        wr_en = 1'b1;
        #1;
        check_val("post_rst_mem_en", 32'(wr_mem_en), 32'd1);
        check_val("post_rst_addr",   32'(wr_addr),   32'd0);
        tick();
        check_val("post_rst_level", 32'(wr_level),    32'd1);
        check_val("post_rst_gray",  32'(wr_ptr_gray), 32'd1);

        // Wrap: 40 writes, read pointer trails by one entry.
        wr_en = 1'b0;
        async_reset("clr2");
        prev_gray = 5'd0;
        for (int i = 0; i < 40; i++) begin
            wr_en            = 1'b1;
            rd_ptr_gray_sync = g5(i);
            #1;
            check_val("wrap_mem_en", 32'(wr_mem_en), 32'd1);
            check_val("wrap_addr",   32'(wr_addr),   32'(i % 16));
            tick();
            check_val("wrap_gray",   32'(wr_ptr_gray), 32'(g5((i + 1) % 32)));
            check_val("wrap_onebit", 32'($countones(wr_ptr_gray ^ prev_gray)), 32'd1);
            check_val("wrap_level",  32'(wr_level), 32'd1);
            check_val("wrap_full",   32'(full),     32'd0);
            prev_gray = wr_ptr_gray;
        end
        wr_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
